// File: rtl/iic_master_core.sv
// Byte-level I2C master engine: START / repeated START / WRITE / READ / STOP
// driven from a valid/ready command port, with clock stretching support,
// arbitration-loss detection and master ACK/NACK on reads.
module iic_master_core #(
  parameter int CLK_DIV    = 25,
  parameter int DIV_W      = 16,
  parameter int STRETCH_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_rxack,
  output logic       rsp_arb,
  output logic       rsp_err,
  output logic       bus_owned,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_oen_n,
  output logic       sda_oen_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam logic [2:0] C_START = 3'b001;
  localparam logic [2:0] C_WRITE = 3'b010;
  localparam logic [2:0] C_READ  = 3'b011;
  localparam logic [2:0] C_STOP  = 3'b100;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             ack_q, ack_d;
  logic [7:0]       rx_q, rx_d;
  logic             scl_oen_q, scl_oen_d;
  logic             sda_oen_q, sda_oen_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_rxack_q, rsp_rxack_d;
  logic             rsp_arb_q, rsp_arb_d;
  logic             rsp_err_q, rsp_err_d;
  logic             bus_owned_q, bus_owned_d;

  logic active, stall, tick, sample, last_qtr, data_bit, arb_lost, done, illegal;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rxack = rsp_rxack_q;
  assign rsp_arb   = rsp_arb_q;
  assign rsp_err   = rsp_err_q;
  assign bus_owned = bus_owned_q;
  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen_n = scl_oen_q;
  assign sda_oen_n = sda_oen_q;

  // Next-state logic: command accept, quarter-bit sequencing, sampling and line drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    wdata_d     = wdata_q;
    ack_d       = ack_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rxack_d = rsp_rxack_q;
    rsp_arb_d   = rsp_arb_q;
    rsp_err_d   = rsp_err_q;
    bus_owned_d = bus_owned_q;
    arb_lost    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;

    active   = !cmd_ready;
    // A slave holding SCL low during the high phase freezes bit timing.
    stall    = (STRETCH_EN != 0) && active && (qtr_q == 2'd2) && !scl_i;
    tick     = active && !stall && (cnt_q == DIV_LAST);
    sample   = tick && (qtr_q == 2'd2);
    last_qtr = (qtr_q == 2'd3);
    data_bit = wdata_q[~bit_q[2:0]];

    if (cmd_valid && cmd_ready) begin
      rsp_err_d = 1'b0;
      rsp_arb_d = 1'b0;
      wdata_d   = cmd_wdata;
      ack_d     = cmd_ack;
      cnt_d     = '0;
      qtr_d     = 2'd0;
      bit_d     = 4'd0;
      case (cmd)
        C_START: state_d = S_START;
        C_WRITE: if (state_q == S_HOLD) state_d = S_WRITE; else illegal = 1'b1;
        C_READ:  if (state_q == S_HOLD) state_d = S_READ;  else illegal = 1'b1;
        C_STOP:  if (state_q == S_HOLD) state_d = S_STOP;  else illegal = 1'b1;
        default: illegal = 1'b1;
      endcase
      if (illegal) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    end else if (active) begin
      if (!stall) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (last_qtr) bit_d = bit_q + 4'd1;
      end
      case (state_q)
        S_START: begin
          // SDA must still be high just before we pull it low for START.
          if (tick && (qtr_q == 2'd1) && !sda_i) arb_lost = 1'b1;
          if (tick && last_qtr) begin
            state_d     = S_HOLD;
            bus_owned_d = 1'b1;
            done        = 1'b1;
          end
        end
        S_WRITE: begin
          if (sample && !bit_q[3] && data_bit && !sda_i) arb_lost = 1'b1;
          if (sample && bit_q[3]) rsp_rxack_d = sda_i;
          if (tick && last_qtr && bit_q[3]) begin
            state_d = S_HOLD;
            done    = 1'b1;
          end
        end
        S_READ: begin
          if (sample && !bit_q[3]) rx_d = {rx_q[6:0], sda_i};
          if (tick && last_qtr && bit_q[3]) begin
            state_d     = S_HOLD;
            rsp_rdata_d = rx_q;
            done        = 1'b1;
          end
        end
        S_STOP: begin
          if (sample && !sda_i) arb_lost = 1'b1;
          if (tick && last_qtr) begin
            state_d     = S_IDLE;
            bus_owned_d = 1'b0;
            done        = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (arb_lost) begin
        state_d     = S_IDLE;
        bus_owned_d = 1'b0;
        rsp_arb_d   = 1'b1;
        rsp_valid_d = 1'b1;
      end else if (done) begin
        rsp_valid_d = 1'b1;
      end
    end

    // Line drive is derived from the upcoming state so pads switch on the same edge.
    scl_oen_d = 1'b1;
    sda_oen_d = 1'b1;
    case (state_d)
      S_HOLD: begin
        scl_oen_d = 1'b0;
        sda_oen_d = sda_oen_q;
      end
      S_START: begin
        scl_oen_d = (qtr_d != 2'd3);
        sda_oen_d = !qtr_d[1];
      end
      S_WRITE: begin
        scl_oen_d = qtr_d[1];
        sda_oen_d = bit_d[3] ? 1'b1 : wdata_d[~bit_d[2:0]];
      end
      S_READ: begin
        scl_oen_d = qtr_d[1];
        sda_oen_d = bit_d[3] ? ack_d : 1'b1;
      end
      S_STOP: begin
        scl_oen_d = (qtr_d != 2'd0);
        sda_oen_d = qtr_d[1];
      end
      default: begin
        scl_oen_d = 1'b1;
        sda_oen_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      wdata_q     <= 8'h00;
      ack_q       <= 1'b0;
      rx_q        <= 8'h00;
      scl_oen_q   <= 1'b1;
      sda_oen_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_rxack_q <= 1'b0;
      rsp_arb_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      bus_owned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      rx_q        <= rx_d;
      scl_oen_q   <= scl_oen_d;
      sda_oen_q   <= sda_oen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rxack_q <= rsp_rxack_d;
      rsp_arb_q   <= rsp_arb_d;
      rsp_err_q   <= rsp_err_d;
      bus_owned_q <= bus_owned_d;
    end
  end

endmodule

// File: tb/tb_iic_master_core.sv
// Directed bench for iic_master_core with CLK_DIV=4 (16 clk per bit).
module tb_iic_master_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] cmd_wdata;
  logic       cmd_ack;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_rxack, rsp_arb, rsp_err, bus_owned;
  logic       scl_i, sda_i, scl_o, sda_o, scl_oen_n, sda_oen_n;

  logic slave_sda   = 1'b1;
  logic stretch_low = 1'b0;
  logic force_low   = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic scl_prev = 1'b1;
  logic rise_q[$];

  // Wired-AND open-drain bus with pull-ups.
  assign scl_i = scl_oen_n & ~stretch_low;
  assign sda_i = sda_oen_n & slave_sda & ~force_low;

  iic_master_core #(.CLK_DIV(4), .DIV_W(16), .STRETCH_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rxack(rsp_rxack),
    .rsp_arb(rsp_arb), .rsp_err(rsp_err), .bus_owned(bus_owned),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .scl_oen_n(scl_oen_n), .sda_oen_n(sda_oen_n)
  );

  always #5 clk = ~clk;

  // Record SDA at every SCL rising edge.
  always @(negedge clk) begin
    scl_prev <= scl_i;
    if (scl_i && !scl_prev) rise_q.push_back(sda_i);
  end

  // Issue one command and play the slave cycle by cycle until rsp_valid.
  // mode 0: slave idle, 1: slave ACKs 9th bit, 2: slave sends sbyte.
  task automatic do_cmd(input logic [2:0] c, input logic [7:0] wd, input logic ak,
                        input int mode, input logic [7:0] sbyte, input int stretch_at,
                        input int force_at, input int rst_at,
                        output int lat, output logic sda9);
    int kk;
    cmd = c; cmd_wdata = wd; cmd_ack = ak; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat  = -1;
    sda9 = 1'bx;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (rst_at >= 0 && k == rst_at + 1) begin
        rst_n = 1'b1;
        lat = k;
        break;
      end
      kk = (stretch_at >= 0 && k >= stretch_at + 22) ? k - 20 : k;
      stretch_low = (stretch_at >= 0 && k >= stretch_at && k < stretch_at + 22);
      force_low   = (force_at >= 0 && k >= force_at && k < force_at + 4);
      if (mode == 1)      slave_sda = (kk / 16 == 8) ? 1'b0 : 1'b1;
      else if (mode == 2) slave_sda = (kk / 16 < 8) ? sbyte[3'(7 - kk / 16)] : 1'b1;
      else                slave_sda = 1'b1;
      if (k == 136) sda9 = sda_oen_n;
      if (rst_at >= 0 && k == rst_at) rst_n = 1'b0;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    slave_sda = 1'b1; stretch_low = 1'b0; force_low = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; cmd_wdata = 8'h00; cmd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", cmd_ready); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n} !== 2'b11) $display("FAIL rst_oen: got %b expected 11", {scl_oen_n, sda_oen_n}); else n_pass++;
    n_chk++; if ({rsp_valid, rsp_rxack, rsp_arb, rsp_err, bus_owned} !== 5'b0) $display("FAIL rst_rsp: got %b expected 00000", {rsp_valid, rsp_rxack, rsp_arb, rsp_err, bus_owned}); else n_pass++;
    n_chk++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", rsp_rdata); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_idle_illegal();
    int lat; logic s9;
    do_cmd(3'b010, 8'h55, 1'b0, 0, 8'h00, -1, -1, -1, lat, s9);
    $display("IDLE WRITE: lat=%0d err=%b", lat, rsp_err);
    n_chk++; if (lat !== 0) $display("FAIL idle_write_lat: got %0d expected 0", lat); else n_pass++;
    n_chk++; if (rsp_err !== 1'b1) $display("FAIL idle_write_err: got %b expected 1", rsp_err); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n, bus_owned} !== 3'b110) $display("FAIL idle_write_bus: got %b expected 110", {scl_oen_n, sda_oen_n, bus_owned}); else n_pass++;
    do_cmd(3'b100, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1, lat, s9);
    $display("IDLE STOP: lat=%0d err=%b", lat, rsp_err);
    n_chk++; if (lat !== 0) $display("FAIL idle_stop_lat: got %0d expected 0", lat); else n_pass++;
    n_chk++; if (rsp_err !== 1'b1) $display("FAIL idle_stop_err: got %b expected 1", rsp_err); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n, bus_owned} !== 3'b110) $display("FAIL idle_stop_bus: got %b expected 110", {scl_oen_n, sda_oen_n, bus_owned}); else n_pass++;
  endtask

  task automatic test_start();
    int lat; logic s9;
    do_cmd(3'b001, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1, lat, s9);
    $display("START: lat=%0d owned=%b", lat, bus_owned);
    n_chk++; if (lat !== 16) $display("FAIL start_lat: got %0d expected 16", lat); else n_pass++;
    n_chk++; if (bus_owned !== 1'b1) $display("FAIL start_owned: got %b expected 1", bus_owned); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n} !== 2'b00) $display("FAIL start_oen: got %b expected 00", {scl_oen_n, sda_oen_n}); else n_pass++;
    n_chk++; if ({rsp_err, rsp_arb} !== 2'b00) $display("FAIL start_flags: got %b expected 00", {rsp_err, rsp_arb}); else n_pass++;
  endtask

  task automatic test_write(input int stretch_at, input int exp_lat);
    int lat; logic s9; logic [8:0] v;
    rise_q.delete();
    do_cmd(3'b010, 8'hA5, 1'b0, 1, 8'h00, stretch_at, -1, -1, lat, s9);
    v = '0;
    foreach (rise_q[i]) v = {v[7:0], rise_q[i]};
    $display("WRITE A5 (stretch_at=%0d): lat=%0d rxack=%b rises=%0d bits=%b", stretch_at, lat, rsp_rxack, rise_q.size(), v);
    n_chk++; if (lat !== exp_lat) $display("FAIL write_lat: got %0d expected %0d", lat, exp_lat); else n_pass++;
    n_chk++; if (rsp_rxack !== 1'b0) $display("FAIL write_rxack: got %b expected 0", rsp_rxack); else n_pass++;
    n_chk++; if (rise_q.size() != 9 || v !== 9'b101001010) $display("FAIL write_bits: got %b (%0d rises) expected 101001010", v, rise_q.size()); else n_pass++;
  endtask

  task automatic test_hold_illegal();
    int lat; logic s9;
    do_cmd(3'b111, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1, lat, s9);
    $display("HOLD cmd 111: lat=%0d err=%b", lat, rsp_err);
    n_chk++; if (lat !== 0) $display("FAIL hold_ill_lat: got %0d expected 0", lat); else n_pass++;
    n_chk++; if (rsp_err !== 1'b1) $display("FAIL hold_ill_err: got %b expected 1", rsp_err); else n_pass++;
    n_chk++; if ({cmd_ready, bus_owned} !== 2'b11) $display("FAIL hold_ill_state: got %b expected 11", {cmd_ready, bus_owned}); else n_pass++;
    n_chk++; if (scl_oen_n !== 1'b0) $display("FAIL hold_ill_scl: got %b expected 0", scl_oen_n); else n_pass++;
  endtask

  task automatic test_read();
    int lat; logic s9;
    do_cmd(3'b011, 8'h00, 1'b1, 2, 8'h3C, -1, -1, -1, lat, s9);
    $display("READ 3C nack: lat=%0d rdata=%h sda9=%b", lat, rsp_rdata, s9);
    n_chk++; if (lat !== 144) $display("FAIL read_lat: got %0d expected 144", lat); else n_pass++;
    n_chk++; if (rsp_rdata !== 8'h3C) $display("FAIL read_rdata: got %h expected 3c", rsp_rdata); else n_pass++;
    n_chk++; if (s9 !== 1'b1) $display("FAIL read_nack_sda: got %b expected 1", s9); else n_pass++;
    n_chk++; if (rsp_rxack !== 1'b0) $display("FAIL read_rxack_kept: got %b expected 0", rsp_rxack); else n_pass++;
  endtask

  task automatic test_stop();
    int lat; logic s9;
    do_cmd(3'b100, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1, lat, s9);
    $display("STOP: lat=%0d owned=%b", lat, bus_owned);
    n_chk++; if (lat !== 16) $display("FAIL stop_lat: got %0d expected 16", lat); else n_pass++;
    n_chk++; if (bus_owned !== 1'b0) $display("FAIL stop_owned: got %b expected 0", bus_owned); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n} !== 2'b11) $display("FAIL stop_oen: got %b expected 11", {scl_oen_n, sda_oen_n}); else n_pass++;
  endtask

  task automatic test_arb();
    int lat; logic s9;
    do_cmd(3'b010, 8'hFF, 1'b0, 1, 8'h00, -1, 40, -1, lat, s9);
    $display("WRITE FF arb: lat=%0d arb=%b owned=%b", lat, rsp_arb, bus_owned);
    n_chk++; if (lat !== 44) $display("FAIL arb_lat: got %0d expected 44", lat); else n_pass++;
    n_chk++; if (rsp_arb !== 1'b1) $display("FAIL arb_flag: got %b expected 1", rsp_arb); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n} !== 2'b11) $display("FAIL arb_oen: got %b expected 11", {scl_oen_n, sda_oen_n}); else n_pass++;
    n_chk++; if ({cmd_ready, bus_owned} !== 2'b10) $display("FAIL arb_state: got %b expected 10", {cmd_ready, bus_owned}); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int lat; logic s9; logic quiet;
    do_cmd(3'b011, 8'h00, 1'b0, 2, 8'hC3, -1, -1, 84, lat, s9);
    $display("READ reset at bit 5: lat=%0d rdata=%h oen=%b", lat, rsp_rdata, {scl_oen_n, sda_oen_n});
    n_chk++; if (lat !== 85) $display("FAIL rstmid_edge: got %0d expected 85", lat); else n_pass++;
    n_chk++; if ({scl_oen_n, sda_oen_n} !== 2'b11) $display("FAIL rstmid_oen: got %b expected 11", {scl_oen_n, sda_oen_n}); else n_pass++;
    n_chk++; if ({cmd_ready, bus_owned} !== 2'b10) $display("FAIL rstmid_state: got %b expected 10", {cmd_ready, bus_owned}); else n_pass++;
    n_chk++; if (rsp_rdata !== 8'h00) $display("FAIL rstmid_rdata: got %h expected 00", rsp_rdata); else n_pass++;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (!scl_oen_n || !sda_oen_n || rsp_valid) quiet = 1'b0;
    end
    $display("post-reset bus quiet=%b", quiet);
    n_chk++; if (quiet !== 1'b1) $display("FAIL rstmid_no_stop: got %b expected 1", quiet); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_illegal();
    test_start();
    test_write(-1, 144);
    test_hold_illegal();
    test_read();
    test_stop();
    test_start();
    test_write(54, 164);
    test_stop();
    test_start();
    test_arb();
    test_start();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
